// File: rtl/upsample_2x.sv
// 2x nearest-neighbour upsampler: each pooled pixel is emitted twice per row, and
// every pooled row is replayed from a line buffer to form the second output row.
module upsample_2x #(
    parameter int width  = 28,
    parameter int height = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done
);

    localparam int HALF_W = width / 2;
    localparam int HALF_H = height / 2;
    localparam int CW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int RW     = (HALF_H > 1) ? $clog2(HALF_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(HALF_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HALF_H - 1);

    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          dup_q, dup_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          run_q;

    logic [15:0]   linebuf_mem [HALF_W];
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic          lb_load;
    logic [CW-1:0] rd_addr;
    logic          in_fire;
    logic          out_fire;

    // run_q keeps in_ready low until the first edge after reset release. The last
    // pixel of a row is not overlapped with a new input: the row replay starts next.
    always_comb begin
        in_ready = run_q && (state_q == ROW_A)
                   && (!out_valid_q || (out_ready && dup_q && (col_q != COL_LAST)));
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        dup_d        = dup_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        lb_load      = 1'b0;
        rd_addr      = '0;
        case (state_q)
            ROW_A: begin
                if (out_fire) begin
                    if (!dup_q) begin
                        dup_d = 1'b1;
                    end else if (col_q == COL_LAST) begin
                        state_d = ROW_B;
                        col_d   = '0;
                        dup_d   = 1'b0;
                        lb_load = 1'b1;
                    end else begin
                        col_d       = col_q + CW'(1);
                        out_valid_d = 1'b0;
                    end
                end
                // A same-cycle input lands in the slot the column counter just moved to.
                if (in_fire) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    dup_d       = 1'b0;
                    wr_en       = 1'b1;
                    wr_addr     = col_d;
                end
            end
            ROW_B: begin
                if (out_fire) begin
                    dup_d = !dup_q;
                    if (dup_q) begin
                        if (col_q == COL_LAST) begin
                            out_valid_d = 1'b0;
                            col_d       = '0;
                            dup_d       = 1'b0;
                            state_d     = ROW_A;
                            if (row_q == ROW_LAST) begin
                                row_d        = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d   = col_q + CW'(1);
                            lb_load = 1'b1;
                            rd_addr = col_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = ROW_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            linebuf_mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ROW_A;
            col_q        <= '0;
            row_q        <= '0;
            dup_q        <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            dup_q        <= dup_d;
            out_data_q   <= lb_load ? linebuf_mem[rd_addr] : out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            run_q        <= 1'b1;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_upsample_2x.sv
// Bench for upsample_2x: a 4x4 instance for handshake/reset scenarios and a default
// 28x28 instance for a full frame, checked against an index-arithmetic reference.
module tb_upsample_2x;

    typedef logic [15:0] q16_t[$];

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][15:0] in_data;
    logic [1:0][15:0] out_data;
    logic [1:0]       in_valid, in_ready, out_valid, out_ready, frame_done;

    always #5 clk = ~clk;

    upsample_2x #(.width(4), .height(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .frame_done(frame_done[0])
    );

    upsample_2x dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .frame_done(frame_done[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    q16_t        got;
    int          fd_cnt, fd_cyc, last_xfer, first_acc, stall_seen, stall_bad;
    logic [15:0] stall_val;

    // Expected stream: output pixel (r, c) of frame f is pooled pixel (r/2, c/2).
    function automatic q16_t model(input q16_t pix, input int w, input int h, input int nframes);
        q16_t e;
        for (int f = 0; f < nframes; f++)
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    e.push_back(pix[f * (w / 2) * (h / 2) + (r / 2) * (w / 2) + c / 2]);
        return e;
    endfunction

    // Samples one negedge: input acceptance, output transfer and frame_done.
    task automatic observe(input int d, output bit acc);
        acc = in_valid[d] && in_ready[d];
        if (acc && first_acc < 0) first_acc = cyc + 1;
        if (out_valid[d] && out_ready[d]) begin
            got.push_back(out_data[d]);
            last_xfer = cyc + 1;
        end
        if (frame_done[d]) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    endtask

    // Streams pix into DUT d until n_out outputs arrive (or abort_at / budget is hit).
    task automatic drive(input int d, input q16_t pix, input int n_out, input int gap_pct,
                         input int rdy_pct, input int stall_at, input int abort_at);
        int sent = 0;
        int budget = 20000;
        int stall_left = 0;
        bit stalled = 0;
        bit acc;
        got.delete();
        fd_cnt = 0; fd_cyc = -1; last_xfer = -1; first_acc = -1;
        stall_seen = 0; stall_bad = 0;
        while (got.size() < n_out && budget > 0) begin
            if (abort_at >= 0 && got.size() == abort_at) break;
            if (stall_at >= 0 && !stalled && got.size() == stall_at && out_valid[d]) begin
                stalled = 1;
                stall_left = 3;
                stall_val = out_data[d];
            end
            in_valid[d]  = (sent < pix.size()) && ($urandom_range(99) >= gap_pct);
            in_data[d]   = in_valid[d] ? pix[sent] : 16'($urandom);
            out_ready[d] = (stall_left == 0) && ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            observe(d, acc);
            if (acc) sent++;
            if (stall_left > 0) begin
                stall_seen++;
                stall_left--;
                if (!out_valid[d] || out_data[d] !== stall_val || acc) stall_bad++;
            end
            @(posedge clk);
            #1;
            budget--;
        end
        in_valid[d] = 1'b0;
        if (abort_at < 0) begin
            repeat (4) begin
                out_ready[d] = 1'b1;
                @(negedge clk);
                observe(d, acc);
                @(posedge clk);
                #1;
            end
        end
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid[0]); end
        checks++; if (out_data[0] !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data[0]); end
        checks++; if (frame_done[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done[0]); end
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready[0]); end
        checks++; if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b0) begin errors++; $display("FAIL reset_large: in_ready %b out_valid %b expected 0 0", in_ready[1], out_valid[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL in_ready_before_edge: got %b expected 0", in_ready[0]); end
        @(posedge clk);
        #1;
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL in_ready_after_edge: got %b expected 1", in_ready[0]); end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        q16_t pix = '{16'd1, 16'd2, 16'd3, 16'd4};
        q16_t exp = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
        drive(0, pix, 16, 0, 100, -1, -1);
        checks++; if (got.size() != 16) begin errors++; $display("FAIL basic_count: got %0d expected 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got[i], exp[i]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL basic_frame_done_count: got %0d expected 1", fd_cnt); end
        checks++; if (fd_cyc != last_xfer) begin errors++; $display("FAIL basic_frame_done_time: got cycle %0d expected %0d", fd_cyc, last_xfer); end
        checks++; if (last_xfer - first_acc != 17) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 17", last_xfer - first_acc); end
        $display("test_basic: %0d outputs, frame_done at cycle %0d", got.size(), fd_cyc);
    endtask

    task automatic test_stall;
        q16_t pix = '{16'd1, 16'd2, 16'd3, 16'd4};
        q16_t exp;
        exp = model(pix, 4, 4, 1);
        drive(0, pix, 16, 0, 100, 2, -1);
        checks++; if (stall_val !== 16'd2) begin errors++; $display("FAIL stall_value: got %0d expected 2", stall_val); end
        checks++; if (stall_seen != 3 || stall_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d cycles %0d violations expected 3 cycles 0 violations", stall_seen, stall_bad); end
        checks++; if (got.size() != 16) begin errors++; $display("FAIL stall_count: got %0d expected 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got[i], exp[i]); end
        end
        $display("test_stall: held %0d cycles at value %0d", stall_seen, stall_val);
    endtask

    task automatic test_reset_midframe;
        q16_t pix1 = '{16'd1, 16'd2, 16'd3, 16'd4};
        q16_t pix2 = '{16'd9, 16'd8, 16'd7, 16'd6};
        q16_t exp = '{9, 9, 8, 8, 9, 9, 8, 8, 7, 7, 6, 6, 7, 7, 6, 6};
        drive(0, pix1, 16, 0, 100, -1, 5);
        checks++; if (got.size() != 5) begin errors++; $display("FAIL midreset_pre_count: got %0d expected 5", got.size()); end
        rst_n = 1'b0;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin errors++; $display("FAIL midreset_async: out_valid %b in_ready %b expected 0 0", out_valid[0], in_ready[0]); end
        @(posedge clk);
        #1;
        checks++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0 || frame_done[0] !== 1'b0) begin errors++; $display("FAIL midreset_held: out_valid %b in_ready %b frame_done %b expected 0 0 0", out_valid[0], in_ready[0], frame_done[0]); end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, pix2, 16, 0, 100, -1, -1);
        checks++; if (got.size() != 16) begin errors++; $display("FAIL midreset_count: got %0d expected 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL midreset_data[%0d]: got %0d expected %0d", i, got[i], exp[i]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL midreset_frame_done: got %0d expected 1", fd_cnt); end
        $display("test_reset_midframe: %0d outputs after reset", got.size());
    endtask

    task automatic test_random(input string name, input int gap_pct, input int rdy_pct);
        q16_t pix;
        q16_t exp;
        for (int i = 0; i < 8; i++) pix.push_back(16'($urandom));
        exp = model(pix, 4, 4, 2);
        drive(0, pix, 32, gap_pct, rdy_pct, -1, -1);
        checks++; if (got.size() != 32) begin errors++; $display("FAIL %s_count: got %0d expected 32", name, got.size()); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got[i], exp[i]); end
        end
        checks++; if (fd_cnt != 2) begin errors++; $display("FAIL %s_frame_done: got %0d expected 2", name, fd_cnt); end
        $display("test_%s: %0d outputs, %0d frame_done pulses", name, got.size(), fd_cnt);
    endtask

    task automatic test_full_frame;
        q16_t pix;
        int bad = 0;
        for (int k = 0; k < 196; k++) pix.push_back(16'(k));
        drive(1, pix, 784, 0, 100, -1, -1);
        checks++; if (got.size() != 784) begin errors++; $display("FAIL full_count: got %0d expected 784", got.size()); end
        for (int i = 0; i < 784 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 16'(((i / 28) / 2) * 14 + (i % 28) / 2)) begin
                errors++;
                if (bad < 8) $display("FAIL full_data[%0d]: got %0d expected %0d", i, got[i], ((i / 28) / 2) * 14 + (i % 28) / 2);
                bad++;
            end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL full_frame_done: got %0d expected 1", fd_cnt); end
        $display("test_full_frame: %0d outputs, %0d frame_done pulses", got.size(), fd_cnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_reset_midframe();
        test_random("random_gaps", 50, 100);
        test_random("random_backpressure", 30, 60);
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
